// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - handshake, data and status bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             o_rd_valid;
  logic             flush;
  logic             clr_err;
  logic             o_fifo_full;
  logic             o_fifo_empty;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [AW:0]      o_count;
  logic             o_overflow;
  logic             o_underflow;

  // Producer/consumer side that drives requests into the FIFO
  modport master (
    output wr_en, wr_data, rd_en, flush, clr_err,
    input  rd_data, o_rd_valid, o_fifo_full, o_fifo_empty,
           o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
  );

  // FIFO side
  modport slave (
    input  wr_en, wr_data, rd_en, flush, clr_err,
    output rd_data, o_rd_valid, o_fifo_full, o_fifo_empty,
           o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with registered or FWFT read
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty, wr_acc, rd_acc;

  // Every status flag decodes from the registered count only
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  assign bus.o_fifo_full    = full;
  assign bus.o_fifo_empty   = empty;
  assign bus.o_almost_full  = (count_q >= AF_C);
  assign bus.o_almost_empty = (count_q <= AE_C);
  assign bus.o_count        = count_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;

  // Next pointers, occupancy and sticky errors; flush overrides both requests
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // A new error in the same cycle as clr_err must survive the clear
    if (!bus.flush && bus.wr_en && full)  overflow_d  = 1'b1;
    if (!bus.flush && bus.rd_en && empty) underflow_d = 1'b1;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; deliberately not reset, a flushed write never lands
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.flush) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  if (FWFT == 0) begin : gen_reg_read
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    // Registered read: load head on an accepted pop, otherwise hold
    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (rd_acc && !bus.flush) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
    end

    // Read output registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.o_rd_valid = rd_valid_q;
  end else begin : gen_fwft_read
    // Head word is presented as soon as the FIFO holds anything; zero when empty
    assign bus.rd_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.o_rd_valid = ~empty;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (registered and FWFT)
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) if0 ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) if1 ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pop0();
    if (sb0.size() != 0) return sb0.pop_front();
    return 8'hxx;
  endfunction

  function automatic logic [7:0] pop1();
    if (sb1.size() != 0) return sb1.pop_front();
    return 8'hxx;
  endfunction

  task automatic idle0();
    if0.wr_en = 0; if0.rd_en = 0; if0.flush = 0; if0.clr_err = 0; if0.wr_data = 0;
  endtask

  task automatic write0(input logic [7:0] d);
    if0.wr_en = 1; if0.wr_data = d; tick(); if0.wr_en = 0;
    sb0.push_back(d);
  endtask

  task automatic read0_check(input logic [3:0] exp_cnt);
    if0.rd_en = 1; tick(); if0.rd_en = 0;
    exp_d = pop0();
    total++; if (if0.o_rd_valid !== 1'b1) $display("FAIL rd_valid got %b exp 1", if0.o_rd_valid); else passed++;
    total++; if (if0.rd_data !== exp_d) $display("FAIL rd_data got %h exp %h", if0.rd_data, exp_d); else passed++;
    total++; if (if0.o_count !== exp_cnt) $display("FAIL rd_count got %0d exp %0d", if0.o_count, exp_cnt); else passed++;
  endtask

  task automatic test_reset();
    idle0();
    if1.wr_en = 0; if1.rd_en = 0; if1.flush = 0; if1.clr_err = 0; if1.wr_data = 0;
    rst_n = 0;
    #22;
    total++; if (if0.o_count !== 4'd0) $display("FAIL rst_count got %0d exp 0", if0.o_count); else passed++;
    total++; if (if0.o_fifo_empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", if0.o_fifo_empty); else passed++;
    total++; if (if0.o_fifo_full !== 1'b0) $display("FAIL rst_full got %b exp 0", if0.o_fifo_full); else passed++;
    total++; if (if0.o_almost_empty !== 1'b1) $display("FAIL rst_ae got %b exp 1", if0.o_almost_empty); else passed++;
    total++; if (if0.o_almost_full !== 1'b0) $display("FAIL rst_af got %b exp 0", if0.o_almost_full); else passed++;
    total++; if ({if0.o_overflow, if0.o_underflow} !== 2'b00) $display("FAIL rst_err got %b exp 00", {if0.o_overflow, if0.o_underflow}); else passed++;
    total++; if (if0.o_rd_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", if0.o_rd_valid); else passed++;
    total++; if (if0.rd_data !== 8'h00) $display("FAIL rst_rd_data got %h exp 00", if0.rd_data); else passed++;
    total++; if (if1.o_rd_valid !== 1'b0) $display("FAIL rst_fwft_valid got %b exp 0", if1.o_rd_valid); else passed++;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      write0(8'(i));
      total++; if (if0.o_count !== 4'(i)) $display("FAIL fill_count got %0d exp %0d", if0.o_count, i); else passed++;
      total++; if (if0.o_almost_empty !== (i <= 2)) $display("FAIL fill_ae got %b at count %0d", if0.o_almost_empty, i); else passed++;
      total++; if (if0.o_almost_full !== (i >= 6)) $display("FAIL fill_af got %b at count %0d", if0.o_almost_full, i); else passed++;
      total++; if (if0.o_fifo_full !== (i == 8)) $display("FAIL fill_full got %b at count %0d", if0.o_fifo_full, i); else passed++;
    end
    // Back-to-back reads with rd_en held high
    if0.rd_en = 1;
    for (int i = 7; i >= 0; i--) begin
      tick();
      exp_d = pop0();
      total++; if (if0.o_rd_valid !== 1'b1) $display("FAIL drain_valid got %b exp 1", if0.o_rd_valid); else passed++;
      total++; if (if0.rd_data !== exp_d) $display("FAIL drain_data got %h exp %h", if0.rd_data, exp_d); else passed++;
      total++; if (if0.o_count !== 4'(i)) $display("FAIL drain_count got %0d exp %0d", if0.o_count, i); else passed++;
    end
    if0.rd_en = 0;
    total++; if (if0.o_fifo_empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", if0.o_fifo_empty); else passed++;
    tick();
    total++; if (if0.o_rd_valid !== 1'b0) $display("FAIL valid_one_cycle got %b exp 0", if0.o_rd_valid); else passed++;
    total++; if (if0.o_underflow !== 1'b0) $display("FAIL no_spurious_udf got %b exp 0", if0.o_underflow); else passed++;
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 8; i++) write0(8'h10 + 8'(i));
    if0.wr_en = 1; if0.wr_data = 8'hEE; tick(); if0.wr_en = 0;
    total++; if (if0.o_overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", if0.o_overflow); else passed++;
    total++; if (if0.o_count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", if0.o_count); else passed++;
    for (int i = 7; i >= 0; i--) read0_check(4'(i));
    if0.rd_en = 1; tick(); if0.rd_en = 0;
    total++; if (if0.o_underflow !== 1'b1) $display("FAIL udf_set got %b exp 1", if0.o_underflow); else passed++;
    total++; if (if0.o_rd_valid !== 1'b0) $display("FAIL udf_valid got %b exp 0", if0.o_rd_valid); else passed++;
    total++; if (if0.o_count !== 4'd0) $display("FAIL udf_count got %0d exp 0", if0.o_count); else passed++;
    // Set and clear together: set wins
    if0.clr_err = 1; if0.rd_en = 1; tick(); if0.rd_en = 0;
    total++; if (if0.o_underflow !== 1'b1) $display("FAIL set_wins got %b exp 1", if0.o_underflow); else passed++;
    total++; if (if0.o_overflow !== 1'b0) $display("FAIL clr_ovf got %b exp 0", if0.o_overflow); else passed++;
    tick(); if0.clr_err = 0;
    total++; if ({if0.o_overflow, if0.o_underflow} !== 2'b00) $display("FAIL clr_err got %b exp 00", {if0.o_overflow, if0.o_underflow}); else passed++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) write0(8'h30 + 8'(i));
    if0.wr_en = 1; if0.rd_en = 1;
    for (int k = 0; k < 20; k++) begin
      if0.wr_data = 8'h40 + 8'(k);
      tick();
      sb0.push_back(8'h40 + 8'(k));
      exp_d = pop0();
      total++; if (if0.o_count !== 4'd4) $display("FAIL sim_count got %0d exp 4", if0.o_count); else passed++;
      total++; if (if0.rd_data !== exp_d || if0.o_rd_valid !== 1'b1) $display("FAIL sim_data got %h/%b exp %h/1", if0.rd_data, if0.o_rd_valid, exp_d); else passed++;
    end
    if0.wr_en = 0; if0.rd_en = 0;
    for (int i = 3; i >= 0; i--) read0_check(4'(i));
    // Read and write while full: write dropped
    for (int i = 0; i < 8; i++) write0(8'h50 + 8'(i));
    if0.wr_en = 1; if0.rd_en = 1; if0.wr_data = 8'hCC; tick(); if0.wr_en = 0; if0.rd_en = 0;
    exp_d = pop0();
    total++; if (if0.o_count !== 4'd7) $display("FAIL full_rw_count got %0d exp 7", if0.o_count); else passed++;
    total++; if (if0.o_overflow !== 1'b1) $display("FAIL full_rw_ovf got %b exp 1", if0.o_overflow); else passed++;
    total++; if (if0.rd_data !== exp_d) $display("FAIL full_rw_data got %h exp %h", if0.rd_data, exp_d); else passed++;
    for (int i = 6; i >= 0; i--) read0_check(4'(i));
    if0.clr_err = 1; tick(); if0.clr_err = 0;
    // Read and write while empty: write accepted, read rejected
    if0.wr_en = 1; if0.rd_en = 1; if0.wr_data = 8'h77; tick(); if0.wr_en = 0; if0.rd_en = 0;
    sb0.push_back(8'h77);
    total++; if (if0.o_count !== 4'd1) $display("FAIL empty_rw_count got %0d exp 1", if0.o_count); else passed++;
    total++; if (if0.o_underflow !== 1'b1) $display("FAIL empty_rw_udf got %b exp 1", if0.o_underflow); else passed++;
    total++; if (if0.o_rd_valid !== 1'b0) $display("FAIL empty_rw_valid got %b exp 0", if0.o_rd_valid); else passed++;
    read0_check(4'd0);
    if0.clr_err = 1; tick(); if0.clr_err = 0;
  endtask

  task automatic test_fwft();
    if1.wr_en = 1; if1.wr_data = 8'hA5; tick(); if1.wr_en = 0;
    sb1.push_back(8'hA5);
    exp_d = sb1[0];
    total++; if (if1.rd_data !== exp_d) $display("FAIL fwft_data got %h exp %h", if1.rd_data, exp_d); else passed++;
    total++; if (if1.o_rd_valid !== 1'b1) $display("FAIL fwft_valid got %b exp 1", if1.o_rd_valid); else passed++;
    total++; if (if1.o_fifo_empty !== 1'b0) $display("FAIL fwft_not_empty got %b exp 0", if1.o_fifo_empty); else passed++;
    if1.wr_en = 1; if1.wr_data = 8'h5A; tick(); if1.wr_en = 0;
    sb1.push_back(8'h5A);
    if1.rd_en = 1; tick(); if1.rd_en = 0;
    exp_d = pop1();
    exp_d = sb1[0];
    total++; if (if1.rd_data !== exp_d) $display("FAIL fwft_next got %h exp %h", if1.rd_data, exp_d); else passed++;
    if1.rd_en = 1; tick(); if1.rd_en = 0;
    exp_d = pop1();
    total++; if (if1.o_fifo_empty !== 1'b1) $display("FAIL fwft_empty got %b exp 1", if1.o_fifo_empty); else passed++;
    total++; if (if1.o_rd_valid !== 1'b0) $display("FAIL fwft_valid_low got %b exp 0", if1.o_rd_valid); else passed++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) write0(8'h60 + 8'(i));
    if0.flush = 1; if0.wr_en = 1; if0.wr_data = 8'h99; tick(); if0.flush = 0; if0.wr_en = 0;
    sb0.delete();
    total++; if (if0.o_count !== 4'd0) $display("FAIL flush_count got %0d exp 0", if0.o_count); else passed++;
    total++; if (if0.o_fifo_empty !== 1'b1) $display("FAIL flush_empty got %b exp 1", if0.o_fifo_empty); else passed++;
    total++; if (if0.o_overflow !== 1'b0) $display("FAIL flush_ovf got %b exp 0", if0.o_overflow); else passed++;
    write0(8'h33);
    read0_check(4'd0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) write0(8'h70 + 8'(i));
    read0_check(4'd5);
    #2;
    rst_n = 0;
    #1;
    total++; if (if0.o_count !== 4'd0) $display("FAIL arst_count got %0d exp 0", if0.o_count); else passed++;
    total++; if (if0.o_fifo_empty !== 1'b1 || if0.o_almost_empty !== 1'b1) $display("FAIL arst_empty got %b%b exp 11", if0.o_fifo_empty, if0.o_almost_empty); else passed++;
    total++; if (if0.o_rd_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", if0.o_rd_valid); else passed++;
    total++; if (if0.rd_data !== 8'h00) $display("FAIL arst_data got %h exp 00", if0.rd_data); else passed++;
    sb0.delete();
    @(posedge clk); #1;
    rst_n = 1;
    write0(8'h81);
    read0_check(4'd0);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_simultaneous();
    test_fwft();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO. It is the synchronous successor to the team's dual-clock 8-bit FIFO, for buffering inside one clock domain. Data width, depth, almost-full/almost-empty thresholds and read mode (registered or first-word-fall-through) are all parameters. It adds occupancy count, sticky overflow/underflow error flags and a synchronous flush, none of which the dual-clock FIFO provides.

## Interface
Parameters:
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥4. AW = log2(DEPTH).
- AF_LEVEL, DEPTH-2: o_almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: o_almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- wr_en, in, 1: write request.
- wr_data, in, WIDTH: write data.
- rd_en, in, 1: read request (FWFT=1: acknowledge/pop).
- rd_data, out, WIDTH: read data.
- o_rd_valid, out, 1: rd_data is valid.
- flush, in, 1: synchronous empty-the-FIFO command.
- clr_err, in, 1: clears the sticky error flags.
- o_fifo_full, out, 1: count == DEPTH.
- o_fifo_empty, out, 1: count == 0.
- o_almost_full, out, 1: count ≥ AF_LEVEL.
- o_almost_empty, out, 1: count ≤ AE_LEVEL.
- o_count, out, AW+1: current occupancy, 0..DEPTH.
- o_overflow, out, 1: sticky flag; a write was attempted while full.
- o_underflow, out, 1: sticky flag; a read was attempted while empty.

## Operation
- Storage: DEPTH×WIDTH array. wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH. A separate count register is AW+1 bits. All status outputs decode from the registered count, so none of them has a combinational path from wr_en or rd_en.
- Write accept: wr_acc = wr_en & ~o_fifo_full. On acceptance, mem[wr_ptr] ← wr_data and wr_ptr increments.
- Read accept: rd_acc = rd_en & ~o_fifo_empty. On acceptance, rd_ptr increments.
- Count update: +1 on write only, −1 on read only, unchanged when both are accepted or neither.
- Simultaneous read and write when full: the read is accepted and the write is dropped, which sets o_overflow.
- Simultaneous read and write when empty: the write is accepted and the read is rejected, which sets o_underflow.
- Sticky errors: o_overflow sets on wr_en & full; o_underflow sets on rd_en & empty. Both clear only on clr_err or reset. If a set condition and clr_err occur in the same cycle, set wins.
- Flush: has priority over wr_en and rd_en in the same cycle. Next cycle: pointers = 0, count = 0, o_rd_valid = 0. Memory contents and error flags are untouched.
- FWFT=0 mode: rd_data is a register loaded from mem[rd_ptr] on rd_acc. Otherwise rd_data holds its value. o_rd_valid = registered rd_acc.
- FWFT=1 mode: rd_data = mem[rd_ptr] whenever the FIFO is not empty. o_rd_valid = ~o_fifo_empty. rd_en pops the head.

## Timing
- Reset values (rst_n low, asynchronous): pointers 0, o_count 0, o_fifo_empty 1, o_fifo_full 0, o_almost_empty 1 (provided AE_LEVEL ≥ 0), o_almost_full 0, o_overflow 0, o_underflow 0, o_rd_valid 0, rd_data 0. Memory is not reset.
- Reset release is synchronous to the clk edge in the integration. The block accepts a write on the first rising edge after rst_n goes high.
- Reset asserted mid-operation: all state returns to reset values immediately, and in-flight data is discarded.
- FWFT=0 latency: rd_en sampled at edge N → rd_data and o_rd_valid valid after edge N, i.e. in cycle N+1. o_rd_valid lasts one cycle per accepted read.
- FWFT=1 latency: a write to an empty FIFO at edge N → o_fifo_empty falls and rd_data shows that word in cycle N+1.
- Flags: all status flags update in the cycle following the accepting edge. Back-to-back accepts at the full clock rate are supported in both directions.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble. Count never exceeds DEPTH and never goes below 0.

## Test plan
Configuration for all scenarios: WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
- Fill then drain, FWFT=0: write 0x01..0x08 on consecutive cycles → o_almost_empty falls at count 3, o_almost_full rises at count 6, o_fifo_full at count 8. Then read 8 times → rd_data 0x01..0x08, each one cycle after rd_en; o_fifo_empty at count 0.
- Overflow/underflow: a 9th write while full → o_overflow=1, o_count stays 8, data unchanged. Drain, then rd_en while empty → o_underflow=1. Pulse clr_err → both flags 0.
- Simultaneous read and write: at count 4, hold wr_en and rd_en for 20 cycles → o_count stays 4, order preserved, pointers wrap twice. Also cover read+write at full (write dropped, count 7) and at empty (write accepted, count 1, o_underflow set).
- FWFT=1: write 0xA5 into an empty FIFO → rd_data=0xA5 and o_rd_valid=1 the next cycle with no rd_en. Pulse rd_en → empty.
- Flush: at count 5, assert flush together with wr_en → next cycle count 0, empty 1; the write is discarded; o_overflow unchanged.
- Async reset mid-stream: drop rst_n between clock edges at count 5 → all outputs reach reset values immediately, without waiting for a clock edge.
